// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID, write-back and ID/EX signal bundle for id_stage
// master: the environment (IF/ID, WB and EX); slave: id_stage itself
interface id_stage_if #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               inst;
  logic [XLEN-1:0]           pc;
  logic                      flush;
  logic                      wb_en;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [XLEN-1:0]           wb_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_pc;
  logic [XLEN-1:0]           out_rs1_data;
  logic [XLEN-1:0]           out_rs2_data;
  logic [XLEN-1:0]           out_imm;
  logic [REG_ADDR_WIDTH-1:0] out_rs1;
  logic [REG_ADDR_WIDTH-1:0] out_rs2;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic [2:0]                out_funct3;
  logic                      out_funct7_5;
  logic                      out_branch;
  logic                      out_memread;
  logic                      out_memtoreg;
  logic                      out_memwrite;
  logic                      out_alusrc;
  logic                      out_regwrite;
  logic                      out_illegal;
  modport master (
    output in_valid, inst, pc, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_funct3, out_funct7_5, out_branch,
           out_memread, out_memtoreg, out_memwrite, out_alusrc, out_regwrite,
           out_illegal
  );
  modport slave (
    input  in_valid, inst, pc, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_funct3, out_funct7_5, out_branch,
           out_memread, out_memtoreg, out_memwrite, out_alusrc, out_regwrite,
           out_illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I/RV64I decode stage with bypassed register file, load-use stall and ID/EX register
// ports: clk, rst (async, active-low), bus (id_stage_if.slave: IF/ID handshake, WB write port, ID/EX outputs)
// ID_ILLEGAL_TRAP_EN: when defined, unknown opcodes are issued with out_illegal set
module id_stage #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  typedef struct packed {
    logic                      valid;
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           rs1_data;
    logic [XLEN-1:0]           rs2_data;
    logic [XLEN-1:0]           imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                funct3;
    logic                      funct7_5;
    logic [5:0]                ctrl;
    logic                      illegal;
  } idex_t;
  logic [XLEN-1:0]           regs_q [NREG];
  logic [XLEN-1:0]           regs_d [NREG];
  idex_t                     idex_q, idex_d;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [31:0]               imm_i, imm_s, imm_b, imm_u, imm_j;
  logic signed [31:0]        imm32;
  logic [5:0]                ctrl;
  logic                      illegal, used1, used2, hazard, load;
  assign rs1   = REG_ADDR_WIDTH'(bus.inst[19:15]);
  assign rs2   = REG_ADDR_WIDTH'(bus.inst[24:20]);
  assign rd    = REG_ADDR_WIDTH'(bus.inst[11:7]);
  assign imm_i = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign imm_s = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
  assign imm_b = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7], bus.inst[30:25], bus.inst[11:8], 1'b0};
  assign imm_u = {bus.inst[31:12], 12'b0};
  assign imm_j = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12], bus.inst[20], bus.inst[30:21], 1'b0};
  // regs_d is next-state and, read combinationally, doubles as the same-cycle bypass
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en && bus.wb_addr != '0) regs_d[bus.wb_addr] = bus.wb_data;
  end
  // ctrl = {branch, memread, memtoreg, memwrite, alusrc, regwrite}
  always_comb begin
    ctrl    = '0;
    used1   = 1'b0;
    used2   = 1'b0;
    illegal = 1'b0;
    imm32   = '0;
    case (bus.inst[6:0])
      7'b0110011: begin ctrl = 6'b000001; used1 = 1'b1; used2 = 1'b1; end
      7'b0010011: begin ctrl = 6'b000011; used1 = 1'b1; imm32 = imm_i; end
      7'b0000011: begin ctrl = 6'b011011; used1 = 1'b1; imm32 = imm_i; end
      7'b0100011: begin ctrl = 6'b000110; used1 = 1'b1; used2 = 1'b1; imm32 = imm_s; end
      7'b1100011: begin ctrl = 6'b100000; used1 = 1'b1; used2 = 1'b1; imm32 = imm_b; end
      7'b1101111: begin ctrl = 6'b100001; imm32 = imm_j; end
      7'b1100111: begin ctrl = 6'b100011; used1 = 1'b1; imm32 = imm_i; end
      7'b0110111, 7'b0010111: begin ctrl = 6'b000011; imm32 = imm_u; end
      default: illegal = TRAP;
    endcase
  end
  assign hazard = idex_q.valid && idex_q.ctrl[4] && bus.in_valid && idex_q.rd != '0 &&
                  ((used1 && idex_q.rd == rs1) || (used2 && idex_q.rd == rs2));
  assign load = !idex_q.valid || bus.out_ready;
  assign bus.in_ready = load && (!hazard || bus.flush);
  always_comb begin
    idex_d = idex_q;
    if (load && !bus.flush && bus.in_valid && !hazard) begin
      idex_d.valid    = 1'b1;
      idex_d.pc       = bus.pc;
      idex_d.rs1_data = regs_d[rs1];
      idex_d.rs2_data = regs_d[rs2];
      idex_d.imm      = XLEN'(imm32);
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.rd       = rd;
      idex_d.funct3   = bus.inst[14:12];
      idex_d.funct7_5 = bus.inst[30];
      idex_d.ctrl     = ctrl;
      idex_d.illegal  = illegal;
    end else if (load) begin
      idex_d.valid   = 1'b0;
      idex_d.ctrl    = '0;
      idex_d.illegal = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      regs_q <= '{default: '0};
      idex_q <= '0;
    end else begin
      regs_q <= regs_d;
      idex_q <= idex_d;
    end
  assign bus.out_valid    = idex_q.valid;
  assign bus.out_pc       = idex_q.pc;
  assign bus.out_rs1_data = idex_q.rs1_data;
  assign bus.out_rs2_data = idex_q.rs2_data;
  assign bus.out_imm      = idex_q.imm;
  assign bus.out_rs1      = idex_q.rs1;
  assign bus.out_rs2      = idex_q.rs2;
  assign bus.out_rd       = idex_q.rd;
  assign bus.out_funct3   = idex_q.funct3;
  assign bus.out_funct7_5 = idex_q.funct7_5;
  assign {bus.out_branch, bus.out_memread, bus.out_memtoreg,
          bus.out_memwrite, bus.out_alusrc, bus.out_regwrite} = idex_q.ctrl;
  assign bus.out_illegal  = idex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage
module tb_id_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vecs = 0;
  int miss = 0;
`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif
  always #5 clk = ~clk;
  id_stage_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus ();
  id_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    bus.in_valid = v;
    bus.inst = i;
    bus.pc = p;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    tick;
    bus.wb_en = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.inst = '0;
    bus.pc = '0;
    bus.flush = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_imm", 64'(bus.out_imm), 64'h0);
    chk("rst_rd", 64'(bus.out_rd), 64'h0);
    rst = 1'b1;
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd3, 32'h33);
    wr(5'd5, 32'h1234);
    // add x6,x5,x0
    drive(1'b1, 32'h00028333, 32'h100);
    #1;
    chk("add_in_ready", 64'(bus.in_ready), 64'h1);
    chk("add_pre_valid", 64'(bus.out_valid), 64'h0);
    tick;
    chk("add_valid", 64'(bus.out_valid), 64'h1);
    chk("add_rs1_data", 64'(bus.out_rs1_data), 64'h1234);
    chk("add_rs2_data", 64'(bus.out_rs2_data), 64'h0);
    chk("add_regwrite", 64'(bus.out_regwrite), 64'h1);
    chk("add_alusrc", 64'(bus.out_alusrc), 64'h0);
    chk("add_rd", 64'(bus.out_rd), 64'h6);
    chk("add_pc", 64'(bus.out_pc), 64'h100);
    // addi x1,x7,-1 with x7 written back in the same cycle
    drive(1'b1, 32'hFFF38093, 32'h104);
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd7;
    bus.wb_data = 32'hAA;
    tick;
    bus.wb_en = 1'b0;
    chk("byp_rs1_data", 64'(bus.out_rs1_data), 64'hAA);
    chk("byp_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    chk("byp_alusrc", 64'(bus.out_alusrc), 64'h1);
    chk("byp_rs1", 64'(bus.out_rs1), 64'h7);
    // lw x3,0(x2) then add x4,x3,x1
    drive(1'b1, 32'h00012183, 32'h108);
    tick;
    chk("lw_memread", 64'(bus.out_memread), 64'h1);
    chk("lw_memtoreg", 64'(bus.out_memtoreg), 64'h1);
    chk("lw_rs1_data", 64'(bus.out_rs1_data), 64'h22);
    drive(1'b1, 32'h00118233, 32'h10C);
    #1;
    chk("hz_in_ready", 64'(bus.in_ready), 64'h0);
    tick;
    chk("hz_bubble_valid", 64'(bus.out_valid), 64'h0);
    chk("hz_bubble_memread", 64'(bus.out_memread), 64'h0);
    chk("hz_retry_ready", 64'(bus.in_ready), 64'h1);
    tick;
    chk("hz_add_valid", 64'(bus.out_valid), 64'h1);
    chk("hz_add_rd", 64'(bus.out_rd), 64'h4);
    chk("hz_add_rs1_data", 64'(bus.out_rs1_data), 64'h33);
    chk("hz_add_rs2_data", 64'(bus.out_rs2_data), 64'h11);
    // lw x0,0(x2) then add x4,x0,x1: no stall
    drive(1'b1, 32'h00012003, 32'h110);
    tick;
    drive(1'b1, 32'h00100233, 32'h114);
    #1;
    chk("x0_in_ready", 64'(bus.in_ready), 64'h1);
    tick;
    chk("x0_valid", 64'(bus.out_valid), 64'h1);
    chk("x0_rs2_data", 64'(bus.out_rs2_data), 64'h11);
    // sw x3,8(x2), then beq x1,x2,-4 held off by out_ready
    drive(1'b1, 32'h00312423, 32'h118);
    tick;
    chk("sw_memwrite", 64'(bus.out_memwrite), 64'h1);
    chk("sw_imm", 64'(bus.out_imm), 64'h8);
    chk("sw_rs2_data", 64'(bus.out_rs2_data), 64'h33);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFE208EE3, 32'h11C);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'h0);
      tick;
      chk("stall_valid", 64'(bus.out_valid), 64'h1);
      chk("stall_imm", 64'(bus.out_imm), 64'h8);
      chk("stall_pc", 64'(bus.out_pc), 64'h118);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'h1);
    tick;
    chk("beq_imm", 64'(bus.out_imm), 64'hFFFFFFFC);
    chk("beq_branch", 64'(bus.out_branch), 64'h1);
    chk("beq_memwrite", 64'(bus.out_memwrite), 64'h0);
    chk("beq_rs1_data", 64'(bus.out_rs1_data), 64'h11);
    chk("beq_rs2_data", 64'(bus.out_rs2_data), 64'h22);
    // flush together with a load-use hazard
    drive(1'b1, 32'h00012183, 32'h120);
    tick;
    drive(1'b1, 32'h00118233, 32'h124);
    bus.flush = 1'b1;
    #1;
    chk("fl_in_ready", 64'(bus.in_ready), 64'h1);
    tick;
    bus.flush = 1'b0;
    chk("fl_valid", 64'(bus.out_valid), 64'h0);
    chk("fl_regwrite", 64'(bus.out_regwrite), 64'h0);
    // lui x5,0x12345
    drive(1'b1, 32'h123452B7, 32'h128);
    tick;
    chk("lui_valid", 64'(bus.out_valid), 64'h1);
    chk("lui_imm", 64'(bus.out_imm), 64'h12345000);
    chk("lui_alusrc", 64'(bus.out_alusrc), 64'h1);
    chk("lui_regwrite", 64'(bus.out_regwrite), 64'h1);
    // jal x1,8
    drive(1'b1, 32'h008000EF, 32'h12C);
    tick;
    chk("jal_imm", 64'(bus.out_imm), 64'h8);
    chk("jal_branch", 64'(bus.out_branch), 64'h1);
    chk("jal_alusrc", 64'(bus.out_alusrc), 64'h0);
    // unknown opcode 0x7F
    drive(1'b1, 32'h0000007F, 32'h130);
    tick;
    chk("ill_valid", 64'(bus.out_valid), 64'h1);
    chk("ill_flag", 64'(bus.out_illegal), 64'(EXP_ILL));
    chk("ill_regwrite", 64'(bus.out_regwrite), 64'h0);
    chk("ill_branch", 64'(bus.out_branch), 64'h0);
    chk("ill_alusrc", 64'(bus.out_alusrc), 64'h0);
    // asynchronous reset mid-operation
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_valid", 64'(bus.out_valid), 64'h0);
    chk("mrst_imm", 64'(bus.out_imm), 64'h0);
    chk("mrst_pc", 64'(bus.out_pc), 64'h0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'h1);
    tick;
    rst = 1'b1;
    drive(1'b1, 32'h00028333, 32'h200);
    tick;
    chk("post_rst_valid", 64'(bus.out_valid), 64'h1);
    chk("post_rst_rs1_data", 64'(bus.out_rs1_data), 64'h0);
    drive(1'b0, 32'h0, 32'h0);
    tick;
    chk("idle_valid", 64'(bus.out_valid), 64'h0);
    chk("idle_regwrite", 64'(bus.out_regwrite), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Parametrised decode stage that supersedes the fixed-width decoder. It holds the architectural register file with write-back bypass, decodes RV32I/RV64I base opcodes into control bits and a sign-extended immediate, and detects load-use hazards. Results are registered into an internal ID/EX pipeline register under a valid/ready handshake. It sits between the IF/ID register (upstream) and EX (downstream), and takes the write-back port from WB.

## Interface

- `XLEN`, default 32: data width, 32 or 64.
- `REG_ADDR_WIDTH`, default 5: register address width; the file holds 2^REG_ADDR_WIDTH entries.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: IF/ID holds an instruction.
- `in_ready` out 1: stage accepts `inst`/`pc` this cycle.
- `inst` in 32: instruction word.
- `pc` in XLEN: instruction address.
- `flush` in 1: EX redirect; kill the instruction being accepted.
- `wb_en` in 1: register write enable.
- `wb_addr` in REG_ADDR_WIDTH: write address.
- `wb_data` in XLEN: write data.
- `out_valid` out 1: ID/EX register holds a valid instruction.
- `out_ready` in 1: EX consumes the ID/EX contents.
- `out_pc`, `out_rs1_data`, `out_rs2_data`, `out_imm` out XLEN: registered operands.
- `out_rs1`, `out_rs2`, `out_rd` out REG_ADDR_WIDTH: registered register addresses.
- `out_funct3` out 3 and `out_funct7_5` out 1: ALU selectors.
- `out_branch`, `out_memread`, `out_memtoreg`, `out_memwrite`, `out_alusrc`, `out_regwrite` out 1 each: registered control bits.
- `out_illegal` out 1: registered illegal-opcode flag.

## Operation

- Register file:
  - x0 reads 0; writes to x0 are ignored. Writes occur on the rising edge when `wb_en` is high.
  - Reads are combinational. If `wb_en` is high, `wb_addr` equals the read address, and the address is nonzero, the read returns `wb_data` (same-cycle bypass).
- Decode by opcode. Controls listed are 1; all others are 0.
  - R 0110011: regwrite.
  - I-ALU 0010011: alusrc, regwrite.
  - LOAD 0000011: memread, memtoreg, alusrc, regwrite.
  - STORE 0100011: memwrite, alusrc.
  - BRANCH 1100011: branch.
  - JAL 1101111: branch, regwrite.
  - JALR 1100111: branch, alusrc, regwrite.
  - LUI 0110111 and AUIPC 0010111: alusrc, regwrite.
  - Any other opcode: all controls 0.
- Immediate: I, S, B, U and J formats, each sign-extended from inst[31] to XLEN. R-type and unknown opcodes give 0.
- rs1 is "used" by R, I-ALU, LOAD, STORE, BRANCH and JALR. rs2 is "used" by R, STORE and BRANCH.
- Hazard condition, all of the following true:
  - `out_valid`, `out_memread` and `in_valid` are high.
  - `out_rd` is nonzero.
  - `out_rd` equals a used rs1 or a used rs2 of `inst`.
- `load = !out_valid || out_ready`.
- `in_ready = load && (!hazard || flush)`.
- Each cycle with `load` high, the ID/EX register updates as follows:
  - `flush` high: `out_valid` becomes 0, and any accepted instruction is dropped.
  - Else `in_valid && !hazard`: `out_valid` becomes 1 and all `out_*` capture the decoded values.
  - Else (hazard bubble or no input): `out_valid` becomes 0 and the control bits become 0.
- With `load` low, all `out_*` hold their values.

## Timing

- Latency: 1 cycle from acceptance to `out_valid`.
- Throughput: 1 instruction per cycle when no hazard is present.
- A load-use hazard costs exactly one bubble cycle. The dependent instruction is accepted on the following cycle with `in_ready` high.
- A write-back in the same cycle as the read is visible through the bypass. A write-back after capture is not reflected in the ID/EX register; EX forwards it.
- `flush` and a hazard in the same cycle: flush wins. `in_ready` is 1 and a bubble is issued.
- `flush` while `out_ready` is low: no effect. The upstream stage holds `flush` until `in_ready` is high.
- Reset, including when asserted mid-operation:
  - `out_valid` and all `out_*` are 0.
  - All registers are 0.
  - `in_ready` follows the formula above and is therefore 1.

## Configuration

- `ID_ILLEGAL_TRAP_EN` defined:
  - Opcodes outside the decode list capture `out_illegal = 1` with `out_valid = 1`.
  - `out_regwrite`, `out_memwrite`, `out_memread` and `out_branch` are forced to 0 for those opcodes.
- `ID_ILLEGAL_TRAP_EN` undefined:
  - `out_illegal` is tied to 0.
  - Unknown opcodes pass through as a NOP with all controls 0.

## Test plan

- Reset then write-back of x5 = 0x1234, followed by decode of `add x6,x5,x0`: expect `out_rs1_data = 0x1234`, `out_regwrite = 1`, and `out_valid` one cycle after acceptance.
- Same-cycle bypass: `wb_en = 1`, `wb_addr = 7`, `wb_data = 0xAA` while decoding `addi x1,x7,-1`: expect `out_rs1_data = 0xAA` and `out_imm = 0xFFFFFFFF` (XLEN = 32).
- `lw x3,0(x2)` followed by `add x4,x3,x1`:
  - Expect `in_ready = 0` for one cycle and one bubble with `out_valid = 0`.
  - The add is then accepted.
  - With rd = x0, no stall occurs.
- `out_ready = 0` for 3 cycles with `in_valid` high: expect `in_ready = 0` and all `out_*` stable. On release, the next instruction is captured.
- `flush` asserted together with a hazard: expect `in_ready = 1` and `out_valid = 0` on the next cycle.
- Opcode 0x7F with `ID_ILLEGAL_TRAP_EN` defined: expect `out_illegal = 1` and `out_regwrite = 0`. With the macro undefined: `out_illegal = 0` and all controls 0.
